retire_trace_encoder: RTL and testbench

- Hardware producer for the CPU commit trace.
- Each cycle it samples the writeback-stage register write, the memory-stage load/store and halt, and queues them in an event FIFO. It serializes them into 16-bit trace words on a valid/ready stream, with a cycle/instruction summary at halt.
- Sits beside `cpu`, tapping its writeback and memory stage signals; the stream feeds a host-side or on-chip trace sink.

---
 rtl/trace_pkg.sv | 47 ++++
 rtl/trace_event_fifo.sv | 48 ++++
 rtl/retire_trace_encoder.sv | 180 ++++++++++++++++++
 tb/tb_retire_trace_encoder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the retire trace encoder: trace type codes, serializer states, event entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package trace_pkg;

    localparam logic [3:0] TR_REG   = 4'h1;
    localparam logic [3:0] TR_LOAD  = 4'h2;
    localparam logic [3:0] TR_STORE = 4'h3;
    localparam logic [3:0] TR_HALT  = 4'h4;

    typedef enum logic [1:0] {
        MK_NONE,
        MK_LOAD,
        MK_STORE
    } mem_kind_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REG_H,
        ST_REG_D,
        ST_MEM_H,
        ST_MEM_A,
        ST_MEM_D,
        ST_HLT_H,
        ST_HLT_C,
        ST_HLT_I,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic        hlt;
        logic        reg_we;
        logic [3:0]  reg_dst;
        logic [15:0] reg_data;
        mem_kind_t   mem_kind;
        logic [15:0] mem_addr;
        logic [15:0] mem_value;
    } event_t;

    localparam int EVENT_W = $bits(event_t);

    // Header word for a memory group; only called for entries that carry a memory access.
    function automatic logic [15:0] mem_hdr(input mem_kind_t kind);
        return {(kind == MK_STORE) ? TR_STORE : TR_LOAD, 12'h000};
    endfunction

endpackage

// File: rtl/trace_event_fifo.sv
// Synchronous event FIFO with extra-MSB wrap pointers; head is read combinationally.
// Latency: a pushed entry is at the head on the edge after the push into an empty FIFO.
// Backpressure: a push while full is discarded unless a pop happens in the same cycle.
module trace_event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer advance; a full FIFO still accepts a push when the head leaves in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/retire_trace_encoder.sv
// Captures retire events into a FIFO and serializes them as 16-bit trace words, with a halt summary.
// Latency: an event into an empty, idle encoder shows its first word one edge after capture.
// Backpressure: words hold while out_ready is low; events arriving at a full FIFO are dropped and flag overflow.
module retire_trace_encoder
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_we,
    input  logic [3:0]  reg_dst,
    input  logic [15:0] reg_data,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        hlt,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    output logic        done
);

    logic        halted;
    logic [15:0] cycle_cnt;
    logic [15:0] inst_cnt;
    state_t      state;
    event_t      in_ev;
    event_t      head;
    logic        capture;
    logic        full;
    logic        empty;
    logic        fire;
    logic        last;
    logic        pop;

    assign capture = (reg_we | mem_rd | mem_wr | hlt) & ~halted;
    assign fire    = out_valid & out_ready;
    assign pop     = fire & last;

    // Build the entry for this cycle; a store takes priority over a load.
    always_comb begin
        in_ev.hlt       = hlt;
        in_ev.reg_we    = reg_we;
        in_ev.reg_dst   = reg_dst;
        in_ev.reg_data  = reg_data;
        in_ev.mem_addr  = mem_addr;
        in_ev.mem_kind  = MK_NONE;
        in_ev.mem_value = 16'h0000;
        if (mem_wr) begin
            in_ev.mem_kind  = MK_STORE;
            in_ev.mem_value = mem_wdata;
        end else if (mem_rd) begin
            in_ev.mem_kind  = MK_LOAD;
            in_ev.mem_value = mem_rdata;
        end
    end

    // The head entry is released only once its final word has been accepted.
    always_comb begin
        last = 1'b0;
        case (state)
            ST_REG_D: last = (head.mem_kind == MK_NONE) && !head.hlt;
            ST_MEM_D: last = !head.hlt;
            ST_HLT_I: last = 1'b1;
            default:  last = 1'b0;
        endcase
    end

    trace_event_fifo #(
        .WIDTH (EVENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture),
        .push_data (in_ev),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    // Counters and halted latch; the halt cycle itself is still counted, everything after is frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted    <= 1'b0;
            cycle_cnt <= 16'h0000;
            inst_cnt  <= 16'h0000;
        end else if (!halted) begin
            cycle_cnt <= cycle_cnt + 16'd1;
            if (hlt | reg_we | mem_wr) inst_cnt <= inst_cnt + 16'd1;
            if (hlt) halted <= 1'b1;
        end
    end

    // Sticky drop flag: a capture into a full FIFO with no simultaneous pop is lost.
    always_ff @(posedge clk) begin
        if (rst)                          overflow <= 1'b0;
        else if (capture && full && !pop) overflow <= 1'b1;
    end

    // Serializer: the state names the word currently presented on out_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (!empty) begin
                    out_valid <= 1'b1;
                    if (head.reg_we) begin
                        state    <= ST_REG_H;
                        out_data <= {TR_REG, head.reg_dst, 8'h00};
                    end else if (head.mem_kind != MK_NONE) begin
                        state    <= ST_MEM_H;
                        out_data <= mem_hdr(head.mem_kind);
                    end else begin
                        state    <= ST_HLT_H;
                        out_data <= {TR_HALT, 12'h000};
                    end
                end
                ST_REG_H: if (fire) begin
                    state    <= ST_REG_D;
                    out_data <= head.reg_data;
                end
                ST_REG_D: if (fire) begin
                    if (head.mem_kind != MK_NONE) begin
                        state    <= ST_MEM_H;
                        out_data <= mem_hdr(head.mem_kind);
                    end else if (head.hlt) begin
                        state    <= ST_HLT_H;
                        out_data <= {TR_HALT, 12'h000};
                    end else begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                ST_MEM_H: if (fire) begin
                    state    <= ST_MEM_A;
                    out_data <= head.mem_addr;
                end
                ST_MEM_A: if (fire) begin
                    state    <= ST_MEM_D;
                    out_data <= head.mem_value;
                end
                ST_MEM_D: if (fire) begin
                    if (head.hlt) begin
                        state    <= ST_HLT_H;
                        out_data <= {TR_HALT, 12'h000};
                    end else begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                ST_HLT_H: if (fire) begin
                    state    <= ST_HLT_C;
                    out_data <= cycle_cnt;
                end
                ST_HLT_C: if (fire) begin
                    state    <= ST_HLT_I;
                    out_data <= inst_cnt;
                end
                ST_HLT_I: if (fire) begin
                    state     <= ST_DONE;
                    out_valid <= 1'b0;
                    done      <= 1'b1;
                end
                ST_DONE: state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_retire_trace_encoder.sv
// Directed bench for retire_trace_encoder with immediate-assertion checks.
// Latency: words are checked one edge apart under continuous out_ready.
// Backpressure: out_ready is driven low for stall and overflow scenarios.
module tb_retire_trace_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_we = 1'b0;
    logic [3:0]  reg_dst = 4'h0;
    logic [15:0] reg_data = 16'h0000;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [15:0] mem_addr = 16'h0000;
    logic [15:0] mem_wdata = 16'h0000;
    logic [15:0] mem_rdata = 16'h0000;
    logic        hlt = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        overflow;
    logic        done;

    int total = 0;
    int bad   = 0;
    int waited;
    logic [15:0] held;

    retire_trace_encoder #(.DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .reg_we    (reg_we),
        .reg_dst   (reg_dst),
        .reg_data  (reg_data),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .hlt       (hlt),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one capture cycle, then return the inputs to idle.
    task automatic ev(input logic we, input logic [3:0] dst, input logic [15:0] d,
                      input logic rd, input logic wr, input logic [15:0] a,
                      input logic [15:0] wd, input logic [15:0] rdt, input logic h);
        reg_we = we; reg_dst = dst; reg_data = d;
        mem_rd = rd; mem_wr = wr; mem_addr = a;
        mem_wdata = wd; mem_rdata = rdt; hlt = h;
        tick();
        reg_we = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; hlt = 1'b0;
    endtask

    // Wait (bounded) for a valid word, compare it, and let the next edge accept it.
    task automatic expect_word(input string tag, input logic [15:0] exp, output int w);
        w = 0;
        while (!out_valid && w < 40) begin
            tick();
            w++;
        end
        check({tag, "_valid"}, {31'h0, out_valid}, 32'd1);
        check(tag, {16'h0, out_data}, {16'h0, exp});
        tick();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_valid", {31'h0, out_valid}, 32'd0);
        check("rst_data", {16'h0, out_data}, 32'd0);
        check("rst_overflow", {31'h0, overflow}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        rst = 1'b0;
        tick();

        // Single register write: first word one edge after capture, then back-to-back
        ev(1'b1, 4'd3, 16'hBEEF, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
        expect_word("reg_hdr", 16'h1300, waited);
        check("reg_latency", waited, 32'd1);
        expect_word("reg_data", 16'hBEEF, waited);
        check("reg_b2b", waited, 32'd0);
        check("reg_idle_after", {31'h0, out_valid}, 32'd0);

        // Register write plus load in one cycle, with a 4-cycle stall on the load header
        ev(1'b1, 4'd5, 16'h0011, 1'b1, 1'b0, 16'h0040, 16'h0, 16'h1234, 1'b0);
        expect_word("both_reg_hdr", 16'h1500, waited);
        expect_word("both_reg_data", 16'h0011, waited);
        out_ready = 1'b0;
        held = out_data;
        tick(); tick(); tick(); tick();
        check("stall_stable", {16'h0, out_data}, {16'h0, held});
        check("stall_word", {16'h0, out_data}, 32'h2000);
        check("stall_valid", {31'h0, out_valid}, 32'd1);
        out_ready = 1'b1;
        expect_word("both_ld_hdr", 16'h2000, waited);
        check("both_ld_b2b", waited, 32'd0);
        expect_word("both_ld_addr", 16'h0040, waited);
        expect_word("both_ld_data", 16'h1234, waited);
        check("both_b2b", waited, 32'd0);

        // Read and write together: the store wins
        ev(1'b0, 4'd0, 16'h0, 1'b1, 1'b1, 16'h0008, 16'h00AA, 16'h5555, 1'b0);
        expect_word("tie_hdr", 16'h3000, waited);
        expect_word("tie_addr", 16'h0008, waited);
        expect_word("tie_data", 16'h00AA, waited);

        // Nine events with the sink stalled: the ninth is dropped
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++)
            ev(1'b1, 4'(i), 16'hA000 + 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
        check("ovf_set", {31'h0, overflow}, 32'd1);
        held = out_data;
        tick(); tick(); tick(); tick();
        check("ovf_stall_stable", {16'h0, out_data}, {16'h0, held});
        check("ovf_stall_word", {16'h0, out_data}, 32'h1000);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_word($sformatf("ovf_hdr%0d", i), {4'h1, 4'(i), 8'h00}, waited);
            expect_word($sformatf("ovf_data%0d", i), 16'hA000 + 16'(i), waited);
        end
        tick(); tick(); tick(); tick();
        check("ovf_ninth_absent", {31'h0, out_valid}, 32'd0);
        check("ovf_sticky", {31'h0, overflow}, 32'd1);

        // Halt summary: writes in cycles 1-3, halt in cycle 6
        rst = 1'b1;
        out_ready = 1'b0;
        tick();
        tick();
        check("halt_rst_overflow", {31'h0, overflow}, 32'd0);
        rst = 1'b0;
        ev(1'b1, 4'd1, 16'h0101, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
        ev(1'b1, 4'd2, 16'h0202, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
        ev(1'b1, 4'd3, 16'h0303, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
        tick();
        tick();
        ev(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
        ev(1'b1, 4'd9, 16'h9999, 1'b0, 1'b1, 16'h0077, 16'h0066, 16'h0, 1'b0);
        out_ready = 1'b1;
        expect_word("h_r1_hdr", 16'h1100, waited);
        expect_word("h_r1_data", 16'h0101, waited);
        expect_word("h_r2_hdr", 16'h1200, waited);
        expect_word("h_r2_data", 16'h0202, waited);
        expect_word("h_r3_hdr", 16'h1300, waited);
        expect_word("h_r3_data", 16'h0303, waited);
        expect_word("h_hdr", 16'h4000, waited);
        expect_word("h_cycles", 16'h0006, waited);
        expect_word("h_insts", 16'h0004, waited);
        check("h_done", {31'h0, done}, 32'd1);
        check("h_valid_low", {31'h0, out_valid}, 32'd0);
        ev(1'b1, 4'd4, 16'h4444, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
        tick(); tick(); tick(); tick();
        check("h_ignored", {31'h0, out_valid}, 32'd0);
        check("h_done_held", {31'h0, done}, 32'd1);

        // Reset mid-packet after the register header has been accepted
        rst = 1'b1;
        tick();
        check("mid_rst_done", {31'h0, done}, 32'd0);
        rst = 1'b0;
        tick();
        ev(1'b1, 4'd7, 16'h7777, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
        expect_word("mid_hdr", 16'h1700, waited);
        rst = 1'b1;
        tick();
        check("mid_valid", {31'h0, out_valid}, 32'd0);
        check("mid_overflow", {31'h0, overflow}, 32'd0);
        rst = 1'b0;
        tick(); tick(); tick();
        check("mid_abandoned", {31'h0, out_valid}, 32'd0);
        ev(1'b1, 4'd2, 16'h2222, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
        expect_word("fresh_hdr", 16'h1200, waited);
        check("fresh_latency", waited, 32'd1);
        expect_word("fresh_data", 16'h2222, waited);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
